// File: rtl/risc_v_defs.sv
// Shared definitions for the risc_v core slice: bus width defaults and the
// response-route encoding used by the memory arbiter.
package risc_v_defs;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    ROUTE_NONE,
    ROUTE_IF,
    ROUTE_D
  } route_t;

endpackage

// File: rtl/mem_arbiter_starve_cnt.sv
// Saturating 4-bit counter of consecutive denied fetch cycles; sat flags
// that the limit has been reached.
module starve_cnt #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam logic [3:0] MAX = 4'(STARVE_MAX);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAX)) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign sat = (cnt == MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port synchronous-read memory between instruction
// fetch and load/store; data wins unless fetch has been starved too long.
module mem_arbiter
  import risc_v_defs::*;
#(
  parameter int unsigned ADDR_W     = risc_v_defs::ADDR_W,
  parameter int unsigned DATA_W     = risc_v_defs::DATA_W,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata
);

  logic   starved;
  route_t route, route_next;

  starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_starve_cnt (
    .clk (clk),
    .rst (rst),
    .inc (if_req && !if_gnt),
    .clr (if_gnt || !if_req),
    .sat (starved)
  );

  // Grants depend only on requests and registered state, never on mem_rdata.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!rst) begin
      if (d_req && !(if_req && starved)) begin
        d_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

  assign mem_en    = if_gnt | d_gnt;
  assign mem_we    = d_gnt & d_we;
  assign mem_addr  = d_gnt ? d_addr : if_addr;
  assign mem_wdata = d_gnt ? d_wdata : '0;
  assign mem_be    = d_gnt ? d_be : '0;

  always_comb begin
    route_next = ROUTE_NONE;
    if (if_gnt) begin
      route_next = ROUTE_IF;
    end else if (d_gnt && !d_we) begin
      route_next = ROUTE_D;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      route <= ROUTE_NONE;
    end else begin
      route <= route_next;
    end
  end

  assign if_rvalid = (route == ROUTE_IF);
  assign d_rvalid  = (route == ROUTE_D);
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port, synchronous-read instruction/data memory between the core's instruction-fetch port and its load/store port. Sits between `risc_v_top` and the unified memory that replaces the separate `rom` in `risc_v_cpu`. Data accesses normally win. A starvation counter guarantees fetch progress. Read data is routed back to the granted requester one cycle after the grant.

## Interface

Parameters:

- `ADDR_W`, 32, address width, shared by both masters and the memory.
- `DATA_W`, 32, data width. Byte-enable width is `DATA_W/8`.
- `STARVE_MAX`, 4, consecutive denied fetch-request cycles before fetch is forced to win. Legal range 1..15.

Ports (clock and reset first):

- `clk` in 1: the single clock. Everything is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `if_req` in 1: fetch request.
- `if_addr` in ADDR_W: fetch byte address.
- `if_gnt` out 1: fetch accepted this cycle.
- `if_rvalid` out 1: `if_rdata` valid.
- `if_rdata` out DATA_W: fetched instruction.
- `d_req` in 1: data request.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in ADDR_W: data byte address.
- `d_wdata` in DATA_W: store data.
- `d_be` in DATA_W/8: store byte enables.
- `d_gnt` out 1: data access accepted this cycle.
- `d_rvalid` out 1: `d_rdata` valid (loads only).
- `d_rdata` out DATA_W: load data.
- `mem_en` out 1: memory access this cycle.
- `mem_we` out 1: memory write.
- `mem_addr` out ADDR_W: memory address.
- `mem_wdata` out DATA_W: memory write data.
- `mem_be` out DATA_W/8: memory byte enables.
- `mem_rdata` in DATA_W: read data, valid the cycle after `mem_en && !mem_we`.

## Operation

Grant decision is combinational from the current-cycle requests and registered state:

- **Data wins:** `d_req && !(if_req && starve_cnt == STARVE_MAX)` gives `d_gnt = 1`.
- **Fetch wins:** otherwise, `if_req` gives `if_gnt = 1`.
- `if_gnt` and `d_gnt` are never both 1.
- The memory port mirrors the winner:
  - `mem_en = if_gnt | d_gnt`.
  - `mem_we = d_gnt & d_we`.
  - `mem_addr` is `d_addr` or `if_addr`.
  - `mem_wdata`/`mem_be` pass `d_wdata`/`d_be` when `d_gnt`, else 0.
- A requester holds `req` and its payload stable until it sees `gnt`. The arbiter does not buffer requests.

Starvation counter `starve_cnt` (4 bits):

- Increments, saturating at `STARVE_MAX`, on `if_req && !if_gnt`.
- Clears on `if_gnt` or `!if_req`.

Response route register `route`, values NONE/IF/D:

- Next value is IF on `if_gnt`.
- Next value is D on `d_gnt && !d_we`.
- Otherwise NONE.
- Stores set NONE and produce no `d_rvalid`. A store is complete on its grant.

Response outputs:

- `if_rvalid = (route == IF)` and `d_rvalid = (route == D)`, both registered.
- `if_rdata` and `d_rdata` both carry `mem_rdata`. Each is only meaningful while its own rvalid is high.

Boundary conditions:

- Back-to-back grants are allowed every cycle. A new grant may coincide with the rvalid of the previous one.
- When both requests arrive together and `starve_cnt < STARVE_MAX`, data wins. Fetch wins exactly one cycle once the counter is saturated; the counter then clears.
- With no requests, `mem_en = 0` and `route` becomes NONE.

Reset:

- `starve_cnt = 0` and `route = NONE`, so `if_rvalid = 0` and `d_rvalid = 0`.
- While `rst = 1`, `if_gnt`, `d_gnt` and `mem_en` are forced to 0.
- Reset mid-operation drops any pending response: no rvalid in the cycle after `rst` is sampled high.

## Timing

- Grant to memory command: 0 cycles, combinational.
- Read latency: rvalid asserts exactly 1 cycle after the grant, with data taken from that cycle's `mem_rdata`.
- Worst-case fetch wait under continuous data traffic: `STARVE_MAX` denied cycles, then a grant in the next cycle.
- Throughput: one access per cycle.
- No combinational path from `mem_rdata` to any grant.

## Structure

- Shared package `risc_v_defs`:
  - `ADDR_W`, `DATA_W` defaults.
  - `route_t` enum {`ROUTE_NONE`, `ROUTE_IF`, `ROUTE_D`}.
- One natural sub-module, `starve_cnt`: a saturating counter with `inc`, `clr` and `sat` ports, parameterised by `STARVE_MAX`.
- Grant logic and the route register stay in `mem_arbiter`.
- `risc_v_cpu` instantiates `mem_arbiter` between `risc_v_top` and the memory.

## Test plan

1. **Reset:**
   - Stimulus: hold `rst = 1` for 3 cycles with `if_req = d_req = 1`.
   - Required response: `if_gnt = d_gnt = mem_en = 0` and both rvalid 0 throughout. After release, the first grant goes to data.
2. **Fetch read:**
   - Stimulus: `if_req = 1` alone, `if_addr = 0x10`; memory returns `0x00500093`.
   - Required response: `if_gnt = 1` and `mem_addr = 0x10` in cycle N; `if_rvalid = 1` and `if_rdata = 0x00500093` in cycle N+1.
3. **Contention and starvation:**
   - Stimulus: `if_req` and `d_req` held high continuously, `STARVE_MAX = 4`.
   - Required response: grant pattern D,D,D,D,IF,D,D,D,D,IF repeating. Never both grants together.
4. **Store:**
   - Stimulus: `d_req = 1`, `d_we = 1`, `d_addr = 0x104`, `d_wdata = 0xDEADBEEF`, `d_be = 4'b0011`.
   - Required response: `mem_we = 1` and `mem_be = 0011` in the same cycle; `d_rvalid` stays 0 the next cycle.
5. **Back-to-back mixed:**
   - Stimulus: cycles N..N+2 are load@0x200, fetch@0x20, load@0x204.
   - Required response: `d_rvalid` at N+1, `if_rvalid` at N+2, `d_rvalid` at N+3, each carrying the matching memory word.
6. **Reset mid-read:**
   - Stimulus: load granted in cycle N; `rst = 1` sampled at the end of cycle N.
   - Required response: `d_rvalid = 0` in cycle N+1.
